// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   Sequences MEM-stage loads and stores onto a word-addressed data memory
//   through a req/gnt/rvalid handshake. Accesses that cross a word boundary
//   are split into two word beats. Store data is lane-positioned with byte
//   enables. Load data is merged across beats and sign/zero-extended.
//
// Ports
//   CPU_CLK, CPU_RST       clock (rising edge), async active-high reset
//   req_valid              MEM stage presents an access (stable while stall)
//   req_we                 1 = store, 0 = load
//   req_size               00 byte, 01 half, 10/11 word
//   req_unsigned           zero-extend loads
//   req_addr, req_wdata    byte address, right-aligned store data
//   stall                  freeze the pipeline (combinational)
//   resp_valid, resp_rdata completion pulse and extended load data
//   mem_req, mem_we, mem_be, mem_addr, mem_wdata   registered memory request
//   mem_gnt, mem_rvalid, mem_rdata                  memory response
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int ADDR_W = 30
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [31:0]       d0_q, d0_d;

  // Lane math, derived from the request which is held stable while stalled.
  logic [1:0]        offset;
  logic [3:0]        size_mask;
  logic [7:0]        mask8;
  logic [63:0]       wd64;
  logic              split;
  logic [ADDR_W-1:0] first_addr, second_addr;
  logic [63:0]       rd_pair;
  logic [31:0]       merged;
  logic [31:0]       load_result;

  always_comb begin
    offset = req_addr[1:0];
    case (req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;  // 11 behaves as a word
    endcase
    mask8 = {4'b0000, size_mask} << offset;
    wd64  = {32'b0, req_wdata} << {offset, 3'b000};
    split = |mask8[7:4];
  end

  assign first_addr  = req_addr[ADDR_W+1:2];
  assign second_addr = first_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W

  // Merge is evaluated in the cycle the last beat's data arrives, so the
  // final word comes straight from mem_rdata; an unsplit access never reaches
  // above 32 bits after the shift, so the upper half is don't-care.
  always_comb begin
    rd_pair = (state_q == WAIT1) ? {mem_rdata, d0_q} : {32'b0, mem_rdata};
    merged  = 32'(rd_pair >> {offset, 3'b000});
    case (req_size)
      2'b00:   load_result = {{24{~req_unsigned & merged[7]}},  merged[7:0]};
      2'b01:   load_result = {{16{~req_unsigned & merged[15]}}, merged[15:0]};
      default: load_result = merged;
    endcase
    if (req_we) load_result = '0;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    d0_d         = d0_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_be_d    = mask8[3:0];
          mem_addr_d  = first_addr;
          mem_wdata_d = wd64[31:0];
          state_d     = REQ0;
        end
      end
      REQ0, REQ1: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          d0_d = mem_rdata;
          if (split) begin
            mem_req_d   = 1'b1;
            mem_be_d    = mask8[7:4];
            mem_addr_d  = second_addr;
            mem_wdata_d = wd64[63:32];
            state_d     = REQ1;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
            state_d      = DONE;
          end
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_result;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      d0_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      d0_q         <= d0_d;
    end
  end

  assign stall      = req_valid & (state_q != DONE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every MEM-stage load and store onto the word-addressed data memory through a req/gnt/rvalid handshake.
- Stalls the pipeline while an access is in flight.
- Generates byte enables and shifted write data for stores.
- Splits word-crossing accesses into two word transactions, then merges and sign/zero-extends the load result before writeback.

Parameters:
ADDR_W, 30, word-address width of the data memory port

Ports:
CPU_CLK  in  1  clock, rising edge
CPU_RST  in  1  asynchronous, active-high reset
req_valid  in  1  MEM stage presents an access; held stable while stall=1
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
req_unsigned  in  1  zero-extend the load (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
stall  out  1  freeze the pipeline
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
mem_req  out  1  request to memory
mem_we  out  1  write request
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  write data, lane-positioned
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data or write acknowledge
mem_rdata  in  32  read word

Behaviour:
- Reset (async, immediate): state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata and the internal merge registers all 0.
- stall = req_valid & (state != DONE), combinational.
- All mem_* outputs and resp_* outputs are registered.
- Lane math:
  - o = req_addr[1:0]; n = 1/2/4 bytes.
  - mask8 = ((1<<n)-1) << o, 8 bits wide; lo_be = mask8[3:0], hi_be = mask8[7:4].
  - wd64 = {32'b0, req_wdata} << 8*o; lo_wd = wd64[31:0], hi_wd = wd64[63:32].
  - Split access when hi_be != 0: half at o=3; word at o=1..3.
- Word addresses: first = req_addr[ADDR_W+1:2]; second = first + 1, wrapping modulo 2^ADDR_W.
- FSM:
  - IDLE: on req_valid, drive mem_req=1, mem_we=req_we, mem_be=lo_be, mem_addr=first, mem_wdata=lo_wd; go to REQ0.
  - REQ0: hold all mem_* outputs until mem_gnt=1, then deassert mem_req; go to WAIT0.
  - WAIT0: on mem_rvalid, capture mem_rdata as d0.
    - If split: issue second beat with hi_be, second address, hi_wd; go to REQ1.
    - Else: go to DONE.
  - REQ1 and WAIT1: same rules as REQ0 and WAIT0; capture d1; go to DONE.
  - DONE: resp_valid=1 for exactly this cycle; stall=0; go to IDLE.
    - Load result: m = {d1, d0} >> 8*o. Byte → m[7:0]; half → m[15:0]. Sign-extend, or zero-extend if req_unsigned. Word → m[31:0].
    - Store result: resp_rdata=0.
- Timing:
  - mem_rvalid may arrive ≥1 cycle after the grant cycle, never in the grant cycle.
  - Only one transaction is outstanding at any time.
  - Aligned access with immediate gnt and next-cycle rvalid: 4 cycles IDLE→REQ0→WAIT0→DONE, stall high for 3. A split access adds 2 cycles.
  - The next access may start in the cycle after DONE.
- mem_rvalid in IDLE, REQ0, REQ1 or DONE is ignored.
- req_size=11 is treated as a word access.
- A store split uses two write beats; memory must not be written outside mask8.
- Reset asserted mid-operation aborts the access:
  - mem_req drops asynchronously.
  - No resp_valid is produced.
  - A late mem_rvalid arriving after reset is ignored.

Test Plan:
- LW, addr 0x100, gnt immediate, mem_rdata=0xDEADBEEF at next cycle → mem_addr=0x40, mem_be=1111; resp_rdata=0xDEADBEEF; stall high exactly 3 cycles.
- LB signed, addr 0x103, mem_rdata=0x80123456 → mem_be=1000, resp_rdata=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH, addr 0x207, wdata=0x0000ABCD → beat 1: addr 0x81, be=1000, wdata=0xCD000000; beat 2: addr 0x82, be=0001, wdata=0x000000AB; resp_rdata=0.
- LW, addr 0x302, gnt delayed 3 cycles each beat, d0=0x11223344, d1=0x55667788 → resp_rdata=0x77881122; mem_req held stable until gnt; stall high until DONE.
- LH signed, addr 0xFFFFFFFF with ADDR_W=30 → second beat word address wraps to 0x0000_0000.
- Reset during WAIT0, then mem_rvalid pulses → outputs 0 immediately; no resp_valid. A following aligned LW completes normally.
